// File: rtl/binary_coeff_sampler.sv
// Fetches N_COEF/WORD random words from the simplerng generator into a buffer of
// binary Ring-LWE coefficients and accumulates the Hamming weight of the polynomial.
module binary_coeff_sampler #(
    parameter int WORD   = 32,
    parameter int N_COEF = 256,
    localparam int N_WORDS = N_COEF / WORD,
    localparam int AW      = $clog2(N_WORDS),
    localparam int WW      = $clog2(N_COEF + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic            rng_re,
    input  logic            rng_valid,
    input  logic [WORD-1:0] rng_data,
    output logic            busy,
    output logic            done,
    output logic [WW-1:0]   weight,
    input  logic [AW-1:0]   rd_addr,
    output logic [WORD-1:0] rd_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state;
    state_t next_state;

    logic [AW-1:0]   word_cnt;
    logic [WORD-1:0] mem [N_WORDS];
    logic            capture;
    logic            last_word;

    function automatic logic [WW-1:0] popcount(input logic [WORD-1:0] d);
        logic [WW-1:0] c;
        c = '0;
        for (int i = 0; i < WORD; i++) begin
            c = c + WW'(d[i]);
        end
        return c;
    endfunction

    assign capture   = (state == WAIT) && rng_valid;
    assign last_word = (word_cnt == AW'(N_WORDS - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (start) next_state = REQ;
            REQ:  next_state = WAIT;
            WAIT: if (rng_valid) next_state = last_word ? DONE : REQ;
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        rng_re = (state == REQ);
        busy   = (state == REQ) || (state == WAIT);
        done   = (state == DONE);
    end

    // Weight is cleared only when a new fill is accepted, so it holds after DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            word_cnt <= '0;
            weight   <= '0;
        end else if (state == IDLE && start) begin
            word_cnt <= '0;
            weight   <= '0;
        end else if (capture) begin
            weight <= weight + popcount(rng_data);
            if (!last_word) begin
                word_cnt <= word_cnt + AW'(1);
            end
        end
    end

    // The buffer itself is never reset; contents survive reset and partial fills.
    always_ff @(posedge clk) begin
        if (!reset && capture) begin
            mem[word_cnt] <= rng_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: tb/tb_binary_coeff_sampler.sv
// Directed self-checking bench for binary_coeff_sampler with a small RNG responder.
module tb_binary_coeff_sampler;

    logic        clk;
    logic        reset;
    logic        start;
    logic        rng_re;
    logic        rng_valid;
    logic [31:0] rng_data;
    logic        busy;
    logic        done;
    logic [8:0]  weight;
    logic [2:0]  rd_addr;
    logic [31:0] rd_data;

    int total;
    int bad;

    logic [31:0] fill_words [8];
    logic [31:0] rd_hist [64];
    int          fill_done_cyc;
    int          fill_re_count;
    bit          fill_busy_ok;
    bit          fill_re_consec;
    bit          fill_timeout;
    logic [8:0]  fill_weight;

    binary_coeff_sampler #(.WORD(32), .N_COEF(256)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .rng_re(rng_re),
        .rng_valid(rng_valid),
        .rng_data(rng_data),
        .busy(busy),
        .done(done),
        .weight(weight),
        .rd_addr(rd_addr),
        .rd_data(rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    // Starts a fill and acts as the RNG: answers each rng_re one cycle later,
    // optionally stalling before one word, pulsing start in the stall, or
    // asserting reset once abort_at words have been captured.
    task automatic run_fill(input int stall_word, input int stall_len,
                            input bit start_in_stall, input int abort_at);
        int cyc;
        int idx;
        int wait_cnt;
        bit prev_re;
        fill_done_cyc  = -1;
        fill_re_count  = 0;
        fill_busy_ok   = 1'b1;
        fill_re_consec = 1'b0;
        fill_timeout   = 1'b0;
        fill_weight    = '0;
        for (int i = 0; i < 64; i++) rd_hist[i] = '0;
        @(posedge clk); #1;
        start = 1'b1;
        cyc = 0;
        idx = 0;
        wait_cnt = 0;
        prev_re = 1'b0;
        while (cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            start = 1'b0;
            rng_valid = 1'b0;
            if (cyc < 64) rd_hist[cyc] = rd_data;
            if (abort_at > 0 && idx == abort_at && wait_cnt == 0) begin
                reset = 1'b1;
                return;
            end
            if (wait_cnt > 0) begin
                wait_cnt--;
                if (start_in_stall && idx == stall_word && wait_cnt == 2) start = 1'b1;
                if (wait_cnt == 0) begin
                    rng_valid = 1'b1;
                    rng_data  = (idx < 8) ? fill_words[idx] : 32'h0;
                    idx++;
                end
            end
            if (rng_re === 1'b1) begin
                fill_re_count++;
                if (prev_re) fill_re_consec = 1'b1;
                wait_cnt = 1 + ((idx == stall_word) ? stall_len : 0);
            end
            prev_re = (rng_re === 1'b1);
            if (done === 1'b1) begin
                fill_done_cyc = cyc;
                fill_weight   = weight;
                if (busy !== 1'b0) fill_busy_ok = 1'b0;
                return;
            end
            if (busy !== 1'b1) fill_busy_ok = 1'b0;
        end
        fill_timeout = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            total++;
            if ({rng_re, busy, done} !== 3'b000) begin
                bad++;
                $display("[TB] FAIL reset_ctrl: got re/busy/done=%b required 000", {rng_re, busy, done});
            end
            total++;
            if (weight !== 9'd0) begin
                bad++;
                $display("[TB] FAIL reset_weight: got %0d required 0", weight);
            end
            total++;
            if (rd_data !== 32'h0) begin
                bad++;
                $display("[TB] FAIL reset_rd_data: got %h required 0", rd_data);
            end
        end
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            total++;
            if ({rng_re, busy, done} !== 3'b000) begin
                bad++;
                $display("[TB] FAIL idle_ctrl: got re/busy/done=%b required 000", {rng_re, busy, done});
            end
        end
    endtask

    task automatic test_fixed_pattern();
        for (int k = 0; k < 8; k++) fill_words[k] = 32'h1 << k;
        run_fill(-1, 0, 1'b0, 0);
        total++;
        if (fill_timeout || fill_done_cyc != 17) begin
            bad++;
            $display("[TB] FAIL fixed_done_cycle: got %0d required 17", fill_done_cyc);
        end
        total++;
        if (fill_re_count != 8 || fill_re_consec) begin
            bad++;
            $display("[TB] FAIL fixed_rng_re: got count=%0d consec=%0d required 8/0", fill_re_count, fill_re_consec);
        end
        total++;
        if (!fill_busy_ok) begin
            bad++;
            $display("[TB] FAIL fixed_busy: got busy glitch required busy high until done");
        end
        total++;
        if (fill_weight !== 9'd8) begin
            bad++;
            $display("[TB] FAIL fixed_weight: got %0d required 8", fill_weight);
        end
        for (int k = 0; k < 8; k++) begin
            rd_addr = 3'(k);
            @(posedge clk); #1;
            total++;
            if (rd_data !== (32'h1 << k)) begin
                bad++;
                $display("[TB] FAIL fixed_read[%0d]: got %h required %h", k, rd_data, 32'h1 << k);
            end
        end
    endtask

    task automatic test_extremes();
        for (int k = 0; k < 8; k++) fill_words[k] = 32'hFFFF_FFFF;
        run_fill(-1, 0, 1'b0, 0);
        total++;
        if (fill_timeout || fill_weight !== 9'd256) begin
            bad++;
            $display("[TB] FAIL ones_weight: got %0d required 256", fill_weight);
        end
        @(posedge clk); #1;
        total++;
        if (weight !== 9'd256) begin
            bad++;
            $display("[TB] FAIL ones_weight_hold: got %0d required 256", weight);
        end
        for (int k = 0; k < 8; k++) fill_words[k] = 32'h0;
        run_fill(-1, 0, 1'b0, 0);
        total++;
        if (fill_timeout || fill_weight !== 9'd0) begin
            bad++;
            $display("[TB] FAIL zeros_weight: got %0d required 0", fill_weight);
        end
        for (int k = 0; k < 8; k++) begin
            rd_addr = 3'(k);
            @(posedge clk); #1;
            total++;
            if (rd_data !== 32'h0) begin
                bad++;
                $display("[TB] FAIL zeros_read[%0d]: got %h required 0", k, rd_data);
            end
        end
    endtask

    task automatic test_stall();
        for (int k = 0; k < 8; k++) fill_words[k] = 32'h0000_000F << (4 * k);
        run_fill(3, 5, 1'b1, 0);
        total++;
        if (fill_timeout || fill_done_cyc != 22) begin
            bad++;
            $display("[TB] FAIL stall_done_cycle: got %0d required 22", fill_done_cyc);
        end
        total++;
        if (fill_re_count != 8 || fill_re_consec) begin
            bad++;
            $display("[TB] FAIL stall_rng_re: got count=%0d consec=%0d required 8/0", fill_re_count, fill_re_consec);
        end
        total++;
        if (!fill_busy_ok) begin
            bad++;
            $display("[TB] FAIL stall_busy: got busy glitch required busy high until done");
        end
        total++;
        if (fill_weight !== 9'd32) begin
            bad++;
            $display("[TB] FAIL stall_weight: got %0d required 32", fill_weight);
        end
        rd_addr = 3'd7;
        @(posedge clk); #1;
        total++;
        if (rd_data !== 32'hF000_0000) begin
            bad++;
            $display("[TB] FAIL stall_read7: got %h required f0000000", rd_data);
        end
    endtask

    task automatic test_reset_mid_fill();
        for (int k = 0; k < 8; k++) fill_words[k] = 32'hA000_0000 | 32'(k);
        run_fill(-1, 0, 1'b0, 0);
        for (int k = 0; k < 8; k++) fill_words[k] = 32'hB000_0000 | 32'(k);
        run_fill(-1, 0, 1'b0, 4);
        @(posedge clk); #1;
        reset = 1'b0;
        total++;
        if ({rng_re, busy, done} !== 3'b000 || weight !== 9'd0 || rd_data !== 32'h0) begin
            bad++;
            $display("[TB] FAIL midreset_state: got re/busy/done=%b weight=%0d rd=%h required 000/0/0",
                     {rng_re, busy, done}, weight, rd_data);
        end
        rng_valid = 1'b1;
        rng_data  = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        rng_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            total++;
            if ({rng_re, busy, done} !== 3'b000 || weight !== 9'd0) begin
                bad++;
                $display("[TB] FAIL midreset_idle: got re/busy/done=%b weight=%0d required 000/0",
                         {rng_re, busy, done}, weight);
            end
        end
        for (int k = 0; k < 8; k++) begin
            logic [31:0] exp_word;
            exp_word = (k < 4) ? (32'hB000_0000 | 32'(k)) : (32'hA000_0000 | 32'(k));
            rd_addr = 3'(k);
            @(posedge clk); #1;
            total++;
            if (rd_data !== exp_word) begin
                bad++;
                $display("[TB] FAIL midreset_read[%0d]: got %h required %h", k, rd_data, exp_word);
            end
        end
    endtask

    task automatic test_collision();
        for (int k = 0; k < 8; k++) fill_words[k] = 32'hC000_0000 | 32'(k);
        rd_addr = 3'd2;
        run_fill(-1, 0, 1'b0, 0);
        total++;
        if (rd_hist[7] !== 32'hB000_0002) begin
            bad++;
            $display("[TB] FAIL collision_old: got %h required b0000002", rd_hist[7]);
        end
        total++;
        if (rd_hist[8] !== 32'hC000_0002) begin
            bad++;
            $display("[TB] FAIL collision_new: got %h required c0000002", rd_hist[8]);
        end
        total++;
        if (fill_timeout || fill_weight !== 9'd28) begin
            bad++;
            $display("[TB] FAIL collision_weight: got %0d required 28", fill_weight);
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        reset     = 1'b1;
        start     = 1'b0;
        rng_valid = 1'b0;
        rng_data  = 32'h0;
        rd_addr   = 3'd0;
        test_reset();
        test_fixed_pattern();
        test_extremes();
        test_stall();
        test_reset_mid_fill();
        test_collision();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
